// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: registered pop, occupancy status, sticky overrun.
// Optional registered almost_full flag enabled by defining UART_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo #(
  parameter int unsigned DWIDTH     = 8,
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DWIDTH-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DWIDTH-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  ovr_clr,
  output logic                  almost_full
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [DWIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_c;
  logic                  pop_c;
  logic [CW-1:0]         count_nxt_c;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A push into a full queue is only admitted when a pop frees the slot on the same edge.
  always_comb begin
    pop_c       = rd_en && !empty;
    push_c      = wr_en && (!full || rd_en);
    count_nxt_c = count;
    if (push_c && !pop_c) begin
      count_nxt_c = count + CW'(1);
    end else if (pop_c && !push_c) begin
      count_nxt_c = count - CW'(1);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rd_valid <= pop_c;
      count    <= count_nxt_c;
      if (push_c) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (pop_c) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
      end
      // A dropped byte outranks a simultaneous clear.
      if (wr_en && !push_c) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef UART_FIFO_ALMOST_FULL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nxt_c >= CW'(AF_LEVEL));
    end
  end
`else
  logic unused_af_level;
  assign unused_af_level = ^AF_LEVEL;
  assign almost_full     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios plus biased random traffic against a queue model.
module tb_uart_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DL2   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFL   = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [DL2:0]  count;
  logic          overrun;
  logic          ovr_clr;
  logic          almost_full;

  uart_rx_fifo #(.DWIDTH(DW), .DEPTH_LOG2(DL2), .AF_LEVEL(AFL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .ovr_clr(ovr_clr), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mq[$];     // reference queue contents
  logic [DW-1:0] exp_q[$];  // bytes expected on rd_data, oldest first
  logic          m_ovr;
  logic          pend_valid;
  logic [DW-1:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_af();
`ifdef UART_FIFO_ALMOST_FULL_EN
    return mq.size() >= AFL;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk_status();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("almost_full", 32'(almost_full), 32'(exp_af()));
  endtask

  // One clock of stimulus; model updated from the queue rules, then status checked after the edge.
  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re, input logic oc);
    logic pop_ok;
    logic push_ok;
    wr_en = we; wr_data = wd; rd_en = re; ovr_clr = oc;
    pop_ok  = re && (mq.size() > 0);
    push_ok = we && (mq.size() < DEPTH || re);
    @(posedge clk);
    if (pop_ok) exp_q.push_back(mq.pop_front());
    if (push_ok) mq.push_back(wd);
    if (we && !push_ok) m_ovr = 1'b1;
    else if (oc) m_ovr = 1'b0;
    pend_valid = pop_ok;
    #1;
    chk_status();
    @(negedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; ovr_clr = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ovr      = 1'b0;
    pend_valid = 1'b0;
    last_data  = '0;
  endtask

  // Monitor: every falling edge compares the valid pulse and the data held or popped.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rd_valid", 32'(rd_valid), 32'(pend_valid));
        if (rd_valid) begin
          if (exp_q.size() == 0) begin
            chk("rd_data_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
          end else begin
            last_data = exp_q.pop_front();
            chk("rd_data", 32'(rd_data), 32'(last_data));
          end
        end else begin
          chk("rd_data_hold", 32'(rd_data), 32'(last_data));
        end
        pend_valid = 1'b0;
      end
    end
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; ovr_clr = 1'b0;
    model_reset();
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // ordered push then pop
    cyc(1, 8'h41, 0, 0); cyc(1, 8'h42, 0, 0); cyc(1, 8'h43, 0, 0);
    repeat (3) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // fill, overflow, drain
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    cyc(1, 8'hAA, 0, 0);
    cyc(0, 0, 0, 1);
    // push+pop while full
    cyc(1, 8'h55, 1, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0);

    // pop while empty, then simultaneous push+pop on empty
    cyc(0, 0, 1, 0);
    cyc(1, 8'h99, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // pointer wrap with streaming pairs
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'(8'h10 + i), 0, 0);
      cyc(0, 0, 1, 0);
    end

    // overflow coinciding with clear, then clear alone
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
    cyc(1, 8'hEE, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);

    // almost_full threshold crossing
    for (int i = 0; i < 12; i++) cyc(1, 8'(8'h60 + i), 0, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 8'h7F, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 0, 1, 0);

    // asynchronous reset with five entries queued
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h30 + i), 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    cyc(1, 8'h5A, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);

    // biased random traffic: fill-heavy, balanced, drain-heavy
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic we, re, oc;
        we = ($urandom_range(0, 99) < (ph == 0 ? 80 : (ph == 1 ? 50 : 25)));
        re = ($urandom_range(0, 99) < (ph == 0 ? 25 : (ph == 1 ? 50 : 80)));
        oc = ($urandom_range(0, 99) < 8);
        cyc(we, 8'($urandom), re, oc);
      end
    end
    for (int i = 0; i < 18; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
